// File: rtl/wfg_stim_sine_mc_pkg.sv
// Shared constants for the multi-channel sine stimulus register file:
// field widths, reset values, global register addresses and a byte-lane merge helper.
package wfg_stim_sine_mc_pkg;

  localparam int MAX_CH   = 16;
  localparam int INC_W    = 16;
  localparam int GAIN_W   = 16;
  localparam int OFFSET_W = 18;

  localparam logic [INC_W-1:0]    INC_RST    = 16'h1000;
  localparam logic [GAIN_W-1:0]   GAIN_RST   = 16'h4000;
  localparam logic [OFFSET_W-1:0] OFFSET_RST = 18'h0_0000;

  localparam logic [11:0] ADDR_COMMIT = 12'h100;
  localparam logic [11:0] ADDR_STATUS = 12'h104;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_INC    = 2'd1,
    REG_GAIN   = 2'd2,
    REG_OFFSET = 2'd3
  } reg_sel_e;

  // The widest field is 18 bits, so only byte lanes 0..2 can ever land.
  function automatic logic [OFFSET_W-1:0] byte_merge(
    input logic [OFFSET_W-1:0] old_val,
    input logic [OFFSET_W-1:0] wdat,
    input logic [2:0]          sel
  );
    logic [OFFSET_W-1:0] res;
    res = old_val;
    if (sel[0]) res[7:0]   = wdat[7:0];
    if (sel[1]) res[15:8]  = wdat[15:8];
    if (sel[2]) res[17:16] = wdat[17:16];
    return res;
  endfunction

endpackage

// File: rtl/wfg_stim_sine_ch_regs.sv
// One channel: immediate CTRL, staging/active INC/GAIN/OFFSET, pending flag
// and the one-cycle commit pulse that tells the core to resync phase.
module wfg_stim_sine_ch_regs
  import wfg_stim_sine_mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  reg_sel_e            wr_reg,
  input  logic [OFFSET_W-1:0] wr_dat,
  input  logic [2:0]          wr_sel,
  input  logic                sw_commit,
  input  logic                sync_i,
  output logic                en_o,
  output logic                auto_o,
  output logic [INC_W-1:0]    inc_stg_o,
  output logic [GAIN_W-1:0]   gain_stg_o,
  output logic [OFFSET_W-1:0] offset_stg_o,
  output logic [INC_W-1:0]    inc_act_o,
  output logic [GAIN_W-1:0]   gain_act_o,
  output logic [OFFSET_W-1:0] offset_act_o,
  output logic                pending_o,
  output logic                commit_o
);

  logic                en_q, en_d, auto_q, auto_d;
  logic [INC_W-1:0]    inc_stg_q, inc_stg_d, inc_act_q, inc_act_d;
  logic [GAIN_W-1:0]   gain_stg_q, gain_stg_d, gain_act_q, gain_act_d;
  logic [OFFSET_W-1:0] offset_stg_q, offset_stg_d, offset_act_q, offset_act_d;
  logic                pending_q, pending_d, commit_q, commit_d;
  logic [OFFSET_W-1:0] old_val, merged;
  logic                commit, stg_wr;

  always_comb begin
    old_val = '0;
    case (wr_reg)
      REG_CTRL:   old_val = {16'h0, auto_q, en_q};
      REG_INC:    old_val = {2'b00, inc_stg_q};
      REG_GAIN:   old_val = {2'b00, gain_stg_q};
      REG_OFFSET: old_val = offset_stg_q;
      default:    old_val = '0;
    endcase
    merged = byte_merge(old_val, wr_dat, wr_sel);

    // Auto commit looks at pre-write state, so a coincident staging write
    // lands after the copy and leaves the channel pending.
    commit = sw_commit | (sync_i & auto_q & pending_q);
    stg_wr = wr_en & (wr_reg != REG_CTRL);

    en_d         = en_q;
    auto_d       = auto_q;
    inc_stg_d    = inc_stg_q;
    gain_stg_d   = gain_stg_q;
    offset_stg_d = offset_stg_q;
    inc_act_d    = commit ? inc_stg_q    : inc_act_q;
    gain_act_d   = commit ? gain_stg_q   : gain_act_q;
    offset_act_d = commit ? offset_stg_q : offset_act_q;
    commit_d     = commit;
    pending_d    = stg_wr ? 1'b1 : (commit ? 1'b0 : pending_q);

    if (wr_en) begin
      case (wr_reg)
        REG_CTRL: begin
          en_d   = merged[0];
          auto_d = merged[1];
        end
        REG_INC:    inc_stg_d    = merged[INC_W-1:0];
        REG_GAIN:   gain_stg_d   = merged[GAIN_W-1:0];
        REG_OFFSET: offset_stg_d = merged;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      auto_q       <= 1'b0;
      inc_stg_q    <= INC_RST;
      gain_stg_q   <= GAIN_RST;
      offset_stg_q <= OFFSET_RST;
      inc_act_q    <= INC_RST;
      gain_act_q   <= GAIN_RST;
      offset_act_q <= OFFSET_RST;
      pending_q    <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      en_q         <= en_d;
      auto_q       <= auto_d;
      inc_stg_q    <= inc_stg_d;
      gain_stg_q   <= gain_stg_d;
      offset_stg_q <= offset_stg_d;
      inc_act_q    <= inc_act_d;
      gain_act_q   <= gain_act_d;
      offset_act_q <= offset_act_d;
      pending_q    <= pending_d;
      commit_q     <= commit_d;
    end
  end

  assign en_o         = en_q;
  assign auto_o       = auto_q;
  assign inc_stg_o    = inc_stg_q;
  assign gain_stg_o   = gain_stg_q;
  assign offset_stg_o = offset_stg_q;
  assign inc_act_o    = inc_act_q;
  assign gain_act_o   = gain_act_q;
  assign offset_act_o = offset_act_q;
  assign pending_o    = pending_q;
  assign commit_o     = commit_q;

endmodule

// File: rtl/wfg_stim_sine_mc_wishbone_reg.sv
// Wishbone slave for the multi-channel sine stimulus: address decode,
// single-pulse ack/err, registered read mux, per-channel register banks.
module wfg_stim_sine_mc_wishbone_reg
  import wfg_stim_sine_mc_pkg::*;
#(
  parameter int BUSW   = 32,
  parameter int NUM_CH = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [BUSW/8-1:0]        wbs_sel_i,
  input  logic [BUSW-1:0]          wbs_dat_i,
  input  logic [BUSW-1:0]          wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [BUSW-1:0]          wbs_dat_o,
  input  logic                     sync_i,
  output logic [NUM_CH-1:0]        ctrl_en_q_o,
  output logic [NUM_CH*16-1:0]     inc_val_q_o,
  output logic [NUM_CH*16-1:0]     gain_val_q_o,
  output logic [NUM_CH*18-1:0]     offset_val_q_o,
  output logic [NUM_CH-1:0]        commit_o
);

  logic            ack_q, ack_d, err_q, err_d;
  logic [BUSW-1:0] dat_q, dat_d, rdata;
  logic            req, wr_req, mapped;
  logic [3:0]      ch_idx;
  logic            ch_hit, commit_hit, status_hit;
  reg_sel_e        reg_sel;

  logic                en     [NUM_CH];
  logic                auto_f [NUM_CH];
  logic [INC_W-1:0]    inc_stg    [NUM_CH];
  logic [GAIN_W-1:0]   gain_stg   [NUM_CH];
  logic [OFFSET_W-1:0] offset_stg [NUM_CH];
  logic [NUM_CH-1:0]   pending, ch_wr, sw_commit;

  // Bits outside the decoded window and unused byte lanes are deliberately ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_adr_i[BUSW-1:12], wbs_adr_i[1:0],
                             wbs_dat_i[BUSW-1:OFFSET_W], wbs_sel_i[BUSW/8-1]};

  assign req        = wbs_stb_i & wbs_cyc_i & ~(ack_q | err_q);
  assign wr_req     = req & wbs_we_i;
  assign ch_idx     = wbs_adr_i[7:4];
  assign reg_sel    = reg_sel_e'(wbs_adr_i[3:2]);
  assign ch_hit     = (wbs_adr_i[11:8] == 4'h0) && ({1'b0, ch_idx} < 5'(NUM_CH));
  assign commit_hit = (wbs_adr_i[11:2] == ADDR_COMMIT[11:2]);
  assign status_hit = (wbs_adr_i[11:2] == ADDR_STATUS[11:2]);
  assign mapped     = ch_hit | commit_hit | status_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [INC_W-1:0]    inc_act;
    logic [GAIN_W-1:0]   gain_act;
    logic [OFFSET_W-1:0] offset_act;

    assign ch_wr[c]     = wr_req & ch_hit & (ch_idx == 4'(c));
    assign sw_commit[c] = wr_req & commit_hit & wbs_dat_i[c] & wbs_sel_i[c/8];

    wfg_stim_sine_ch_regs u_ch (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .wr_en        (ch_wr[c]),
      .wr_reg       (reg_sel),
      .wr_dat       (wbs_dat_i[OFFSET_W-1:0]),
      .wr_sel       (wbs_sel_i[2:0]),
      .sw_commit    (sw_commit[c]),
      .sync_i       (sync_i),
      .en_o         (en[c]),
      .auto_o       (auto_f[c]),
      .inc_stg_o    (inc_stg[c]),
      .gain_stg_o   (gain_stg[c]),
      .offset_stg_o (offset_stg[c]),
      .inc_act_o    (inc_act),
      .gain_act_o   (gain_act),
      .offset_act_o (offset_act),
      .pending_o    (pending[c]),
      .commit_o     (commit_o[c])
    );

    assign ctrl_en_q_o[c]           = en[c];
    assign inc_val_q_o[16*c +: 16]  = inc_act;
    assign gain_val_q_o[16*c +: 16] = gain_act;
    assign offset_val_q_o[18*c +: 18] = offset_act;
  end

  // COMMIT reads as zero, so it needs no entry in the mux.
  always_comb begin
    rdata = '0;
    if (status_hit) rdata[NUM_CH-1:0] = pending;
    if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_sel)
            REG_CTRL:   rdata[1:0]          = {auto_f[c], en[c]};
            REG_INC:    rdata[INC_W-1:0]    = inc_stg[c];
            REG_GAIN:   rdata[GAIN_W-1:0]   = gain_stg[c];
            REG_OFFSET: rdata[OFFSET_W-1:0] = offset_stg[c];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    ack_d = req & mapped;
    err_d = req & ~mapped;
    dat_d = (req & ~wbs_we_i & mapped) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wfg_stim_sine_mc_wishbone_reg.sv
// Bench for the sine stimulus register file: directed scenarios plus
// randomized bus traffic checked against an abstract register-map model.
module tb_wfg_stim_sine_mc_wishbone_reg;
  localparam int BUSW   = 32;
  localparam int NUM_CH = 4;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic                 wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_dat_i, wbs_adr_i;
  logic                 wbs_ack_o, wbs_err_o;
  logic [31:0]          wbs_dat_o;
  logic                 sync_i;
  logic [NUM_CH-1:0]    ctrl_en_q_o, commit_o;
  logic [NUM_CH*16-1:0] inc_val_q_o, gain_val_q_o;
  logic [NUM_CH*18-1:0] offset_val_q_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wfg_stim_sine_mc_wishbone_reg #(.BUSW(BUSW), .NUM_CH(NUM_CH)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_err_o      (wbs_err_o),
    .wbs_dat_o      (wbs_dat_o),
    .sync_i         (sync_i),
    .ctrl_en_q_o    (ctrl_en_q_o),
    .inc_val_q_o    (inc_val_q_o),
    .gain_val_q_o   (gain_val_q_o),
    .offset_val_q_o (offset_val_q_o),
    .commit_o       (commit_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain register-map state
  logic [31:0] m_en [NUM_CH], m_auto [NUM_CH], m_pend [NUM_CH];
  logic [31:0] m_inc_s [NUM_CH], m_gain_s [NUM_CH], m_off_s [NUM_CH];
  logic [31:0] m_inc_a [NUM_CH], m_gain_a [NUM_CH], m_off_a [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_auto[c] = 0; m_pend[c] = 0;
      m_inc_s[c] = 32'h1000; m_gain_s[c] = 32'h4000; m_off_s[c] = 0;
      m_inc_a[c] = 32'h1000; m_gain_a[c] = 32'h4000; m_off_a[c] = 0;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] sel, input logic [31:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & mask;
  endfunction

  task automatic model_step(input bit req, input bit we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input bit sync,
                            output bit e_ack, output bit e_err, output logic [31:0] e_dat,
                            output logic [NUM_CH-1:0] e_cm);
    logic [31:0] a;
    bit ch_reg, is_commit, is_status;
    int c, r;
    a = adr & 32'h0000_0FFC;
    ch_reg    = (a < 16 * NUM_CH);
    is_commit = (a == 32'h100);
    is_status = (a == 32'h104);
    e_ack = req && (ch_reg || is_commit || is_status);
    e_err = req && !(ch_reg || is_commit || is_status);
    e_dat = 0;
    c = int'(a / 16);
    r = int'((a % 16) / 4);
    for (int k = 0; k < NUM_CH; k++) begin
      e_cm[k] = sync && m_auto[k] != 0 && m_pend[k] != 0;
      if (req && we && is_commit && sel[k / 8] && dat[k]) e_cm[k] = 1'b1;
    end
    if (e_ack && !we) begin
      if (is_status)
        for (int k = 0; k < NUM_CH; k++) e_dat[k] = (m_pend[k] != 0);
      else if (ch_reg)
        case (r)
          0: e_dat = (m_auto[c] << 1) | m_en[c];
          1: e_dat = m_inc_s[c];
          2: e_dat = m_gain_s[c];
          default: e_dat = m_off_s[c];
        endcase
    end
    for (int k = 0; k < NUM_CH; k++)
      if (e_cm[k]) begin
        m_inc_a[k] = m_inc_s[k]; m_gain_a[k] = m_gain_s[k]; m_off_a[k] = m_off_s[k];
        m_pend[k] = 0;
      end
    if (req && we && ch_reg) begin
      case (r)
        0: begin
          logic [31:0] ctl;
          ctl = merge((m_auto[c] << 1) | m_en[c], dat, sel, 32'h3);
          m_en[c] = ctl & 1; m_auto[c] = (ctl >> 1) & 1;
        end
        1: begin m_inc_s[c]  = merge(m_inc_s[c],  dat, sel, 32'hFFFF);  m_pend[c] = 1; end
        2: begin m_gain_s[c] = merge(m_gain_s[c], dat, sel, 32'hFFFF);  m_pend[c] = 1; end
        default: begin m_off_s[c] = merge(m_off_s[c], dat, sel, 32'h3FFFF); m_pend[c] = 1; end
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      chk_val($sformatf("en[%0d]", c), 32'(ctrl_en_q_o[c]), m_en[c]);
      chk_val($sformatf("inc_act[%0d]", c), 32'(inc_val_q_o[16*c +: 16]), m_inc_a[c]);
      chk_val($sformatf("gain_act[%0d]", c), 32'(gain_val_q_o[16*c +: 16]), m_gain_a[c]);
      chk_val($sformatf("off_act[%0d]", c), 32'(offset_val_q_o[18*c +: 18]), m_off_a[c]);
    end
  endtask

  task automatic drive_idle();
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0; sync_i = 0;
  endtask

  // One request (or a bare sync pulse when req=0), then one idle cycle.
  task automatic bus(input bit req, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input bit sync, output logic [31:0] rd);
    bit e_ack, e_err;
    logic [31:0] e_dat;
    logic [NUM_CH-1:0] e_cm;
    model_step(req, we, adr, dat, sel, sync, e_ack, e_err, e_dat, e_cm);
    wbs_stb_i = req; wbs_cyc_i = req; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; sync_i = sync;
    @(posedge wb_clk_i); #1;
    drive_idle();
    rd = wbs_dat_o;
    chk_val("ack", 32'(wbs_ack_o), 32'(e_ack));
    chk_val("err", 32'(wbs_err_o), 32'(e_err));
    chk_val("rdata", wbs_dat_o, e_dat);
    chk_val("commit_pulse", 32'(commit_o), 32'(e_cm));
    check_outputs();
    @(posedge wb_clk_i); #1;
    chk_val("ack_low", 32'(wbs_ack_o), 0);
    chk_val("err_low", 32'(wbs_err_o), 0);
    chk_val("rdata_idle", wbs_dat_o, 0);
    chk_val("commit_low", 32'(commit_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, adr;
    int acks;
    drive_idle();
    wb_rst_i = 1;
    model_reset();
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 0;
    chk_val("rst_ack", 32'(wbs_ack_o), 0);
    chk_val("rst_err", 32'(wbs_err_o), 0);
    chk_val("rst_dat", wbs_dat_o, 0);
    chk_val("rst_commit", 32'(commit_o), 0);
    check_outputs();

    bus(1, 0, 32'h18, 0, 4'hF, 0, rd);
    chk_val("ch1_gain_read", rd, 32'h4000);
    chk_val("ch1_gain_active", 32'(gain_val_q_o[31:16]), 32'h4000);
    bus(1, 0, 32'h104, 0, 4'hF, 0, rd);
    chk_val("status_reset", rd, 0);

    bus(1, 1, 32'h24, 32'h0000_2345, 4'b0001, 0, rd);
    bus(1, 0, 32'h24, 0, 4'hF, 0, rd);
    chk_val("ch2_inc_staging", rd, 32'h1045);
    chk_val("ch2_inc_active_old", 32'(inc_val_q_o[47:32]), 32'h1000);
    bus(1, 0, 32'h104, 0, 4'hF, 0, rd);
    chk_val("status_ch2_pending", rd, 32'h4);
    bus(1, 1, 32'h100, 32'h4, 4'b0001, 0, rd);
    chk_val("ch2_inc_committed", 32'(inc_val_q_o[47:32]), 32'h1045);
    bus(1, 0, 32'h104, 0, 4'hF, 0, rd);
    chk_val("status_cleared", rd, 0);

    bus(1, 1, 32'h0, 32'h2, 4'hF, 0, rd);
    bus(1, 1, 32'hC, 32'h3FFFF, 4'hF, 0, rd);
    bus(1, 1, 32'h14, 32'h55, 4'hF, 0, rd);
    bus(0, 0, 0, 0, 0, 1, rd);
    chk_val("ch0_off_auto", 32'(offset_val_q_o[17:0]), 32'h3FFFF);
    chk_val("ch1_inc_untouched", 32'(inc_val_q_o[31:16]), 32'h1000);

    bus(1, 0, 32'h200, 0, 4'hF, 0, rd);
    bus(1, 0, 32'h40, 0, 4'hF, 0, rd);
    bus(1, 1, 32'h44, 32'hFFFF, 4'hF, 0, rd);

    // Held strobe: one termination every other cycle
    acks = 0;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h104; wbs_sel_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      acks += int'(wbs_ack_o);
      chk_val($sformatf("held_ack_%0d", i), 32'(wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    drive_idle();
    chk_val("held_ack_count", acks, 3);
    @(posedge wb_clk_i); #1;

    bus(1, 1, 32'h8, 32'h2000, 4'hF, 0, rd);
    bus(1, 1, 32'h8, 32'h1234, 4'hF, 1, rd);
    chk_val("coincident_active", 32'(gain_val_q_o[15:0]), 32'h2000);
    bus(1, 0, 32'h8, 0, 4'hF, 0, rd);
    chk_val("coincident_staging", rd, 32'h1234);
    bus(1, 0, 32'h104, 0, 4'hF, 0, rd);
    chk_val("coincident_pending", rd & 32'h1, 32'h1);

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5)      adr = 32'($urandom_range(0, NUM_CH - 1) * 16 + $urandom_range(0, 3) * 4);
      else if (kind == 6) adr = 32'h100;
      else if (kind == 7) adr = 32'h104;
      else if (kind == 8) adr = 32'($urandom_range(NUM_CH, 15) * 16 + $urandom_range(0, 3) * 4);
      else                adr = 32'($urandom_range(32'h42, 32'h3FF) * 4);
      adr = adr | ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 3));
      bus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, adr, $urandom,
          4'($urandom), $urandom_range(0, 7) == 0, rd);
    end

    // Reset in the middle of a write request: no termination, everything back to defaults
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
    wbs_adr_i = 32'h4; wbs_dat_i = 32'hABCD; wbs_sel_i = 4'hF;
    #2 wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    model_reset();
    chk_val("rst_mid_ack", 32'(wbs_ack_o), 0);
    chk_val("rst_mid_err", 32'(wbs_err_o), 0);
    check_outputs();
    drive_idle();
    wb_rst_i = 0;
    @(posedge wb_clk_i); #1;
    chk_val("rst_mid_ack_after", 32'(wbs_ack_o), 0);
    bus(1, 0, 32'h4, 0, 4'hF, 0, rd);
    chk_val("rst_mid_inc_staging", rd, 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
